// File: rtl/scan_sel_sequencer.sv
// Scan sequencer for a 4-position display: steps sel 0..3 with a dwell and a blanking gap,
// and double-buffers the 16-bit payload so a frame never mixes old and new nibbles.
module scan_sel_sequencer #(
    parameter int unsigned DIV       = 50000,
    parameter int unsigned BLANK_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] data,
    output logic [1:0]  sel,
    output logic [3:0]  digit,
    output logic        blank,
    output logic        frame_done
);

    localparam int unsigned CntMax = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CW-1:0] DivLast = CW'(DIV - 1);
    localparam logic [CW-1:0] GapLast = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    typedef enum logic [1:0] {
        StIdle,
        StShow,
        StGap
    } state_e;

    state_e        state;
    logic [15:0]   shadow;
    logic [15:0]   active;
    logic          pending;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            cnt        <= '0;
            sel        <= 2'd0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (!en) begin
                // Leaving the scan promotes whatever was waiting so IDLE shows the latest data.
                state   <= StIdle;
                sel     <= 2'd0;
                cnt     <= '0;
                blank   <= 1'b1;
                pending <= 1'b0;
                if (load) begin
                    active <= data;
                    shadow <= data;
                end else if (pending) begin
                    active <= shadow;
                end
            end else begin
                case (state)
                    StIdle: begin
                        if (load) begin
                            active <= data;
                            shadow <= data;
                        end
                        state <= StShow;
                        sel   <= 2'd0;
                        cnt   <= '0;
                        blank <= 1'b0;
                    end
                    StShow, StGap: begin
                        if (load) begin
                            shadow  <= data;
                            pending <= 1'b1;
                        end
                        if ((state == StShow && cnt != DivLast) ||
                            (state == StGap && cnt != GapLast)) begin
                            cnt <= cnt + 1'b1;
                        end else if (state == StShow && BLANK_CYC > 0) begin
                            state <= StGap;
                            blank <= 1'b1;
                            cnt   <= '0;
                        end else begin
                            state <= StShow;
                            blank <= 1'b0;
                            cnt   <= '0;
                            sel   <= sel + 2'd1;
                            if (sel == 2'd3) begin
                                // Frame boundary: the only point where a scanning load lands.
                                frame_done <= 1'b1;
                                pending    <= 1'b0;
                                if (load) begin
                                    active <= data;
                                end else if (pending) begin
                                    active <= shadow;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                        blank <= 1'b1;
                        sel   <= 2'd0;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign digit = active[{sel, 2'b00} +: 4];

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Scoreboard bench: two sequencers (DIV=4/BLANK=2 and DIV=1/BLANK=0) against a frame-time model.
module tb_scan_sel_sequencer;

    bit          clk = 1'b0;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;

    logic [1:0] sel_a, sel_b;
    logic [3:0] digit_a, digit_b;
    logic       blank_a, blank_b, fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scan_sel_sequencer #(.DIV(4), .BLANK_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
        .sel(sel_a), .digit(digit_a), .blank(blank_a), .frame_done(fd_a)
    );

    scan_sel_sequencer #(.DIV(1), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
        .sel(sel_b), .digit(digit_b), .blank(blank_b), .frame_done(fd_b)
    );

    // Reference model: time since scan start determines position and blanking directly.
    int unsigned m_div [2] = '{4, 1};
    int unsigned m_blk [2] = '{2, 0};
    bit          m_scan[2];
    int          m_t   [2];
    logic [15:0] m_act [2];
    logic [15:0] m_shv [2];
    bit          m_pend[2];

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    bit          r_q, en_q, ld_q;
    logic [15:0] d_q;

    task automatic model_reset(input int k);
        m_scan[k] = 1'b0;
        m_t[k]    = 0;
        m_act[k]  = '0;
        m_shv[k]  = '0;
        m_pend[k] = 1'b0;
    endtask

    task automatic model_step(input int k, input bit r, input bit e, input bit l,
                              input logic [15:0] d);
        int p;
        p = 4 * int'(m_div[k] + m_blk[k]);
        if (r) begin
            model_reset(k);
        end else if (!e) begin
            m_scan[k] = 1'b0;
            if (l) m_act[k] = d;
            else if (m_pend[k]) m_act[k] = m_shv[k];
            m_pend[k] = 1'b0;
        end else if (!m_scan[k]) begin
            if (l) begin
                m_act[k] = d;
                m_shv[k] = d;
            end
            m_scan[k] = 1'b1;
            m_t[k]    = 0;
        end else begin
            m_t[k] = m_t[k] + 1;
            if (l) begin
                m_shv[k]  = d;
                m_pend[k] = 1'b1;
            end
            if (m_t[k] % p == 0) begin
                if (l) m_act[k] = d;
                else if (m_pend[k]) m_act[k] = m_shv[k];
                m_pend[k] = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] model_out(input int k);
        int         slot, p, ph, s;
        logic [1:0] o_sel;
        logic [3:0] o_dig;
        logic       o_blk, o_fd;
        slot = int'(m_div[k] + m_blk[k]);
        p    = 4 * slot;
        if (m_scan[k]) begin
            ph    = m_t[k] % p;
            s     = ph / slot;
            o_sel = 2'(s);
            o_blk = (ph % slot) >= int'(m_div[k]);
            o_fd  = (m_t[k] > 0) && (ph == 0);
            o_dig = 4'(m_act[k] >> (4 * s));
        end else begin
            o_sel = 2'd0;
            o_blk = 1'b1;
            o_fd  = 1'b0;
            o_dig = m_act[k][3:0];
        end
        return {o_sel, o_dig, o_blk, o_fd};
    endfunction

    // One clock: account for the edge just taken, then drive the inputs for the next edge.
    task automatic cycle(input bit r, input bit e, input bit l, input logic [15:0] d);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r_q, en_q, ld_q, d_q);
        // Asynchronous reset asserted after the edge is visible within this same cycle.
        if (r) for (int k = 0; k < 2; k++) model_reset(k);
        exp_a.push_back(model_out(0));
        exp_b.push_back(model_out(1));
        #1;
        rst  = r;
        en   = e;
        load = l;
        data = d;
        r_q  = r;
        en_q = e;
        ld_q = l;
        d_q  = d;
    endtask

    task automatic compare(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got sel=%0d digit=%h blank=%b frame_done=%b, expected sel=%0d digit=%h blank=%b frame_done=%b",
                     name, $time, got[7:6], got[5:2], got[1], got[0],
                     exp[7:6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (exp_a.size() > 0) begin
                e = exp_a.pop_front();
                compare("dut_a", {sel_a, digit_a, blank_a, fd_a}, e);
            end
            if (exp_b.size() > 0) begin
                e = exp_b.pop_front();
                compare("dut_b", {sel_b, digit_b, blank_b, fd_b}, e);
            end
        end
    end

    initial begin
        int guard;
        rst  = 1'b1;
        en   = 1'b0;
        load = 1'b0;
        data = '0;
        r_q  = 1'b1;
        en_q = 1'b0;
        ld_q = 1'b0;
        d_q  = '0;
        for (int k = 0; k < 2; k++) model_reset(k);

        cycle(1, 0, 0, 16'h0);
        cycle(0, 0, 1, 16'h4321);
        cycle(0, 1, 0, 16'h0);
        repeat (30) cycle(0, 1, 0, 16'h0);

        // Mid-frame load while dut_a shows position 1.
        guard = 0;
        while (m_t[0] % 24 != 7 && guard < 100) begin
            cycle(0, 1, 0, 16'h0);
            guard++;
        end
        cycle(0, 1, 1, 16'hDCBA);
        repeat (40) cycle(0, 1, 0, 16'h0);

        // Pending load, then an overriding load on dut_a's wrap edge.
        cycle(0, 1, 1, 16'h5555);
        guard = 0;
        while (m_t[0] % 24 != 23 && guard < 100) begin
            cycle(0, 1, 0, 16'h0);
            guard++;
        end
        cycle(0, 1, 1, 16'h9999);
        repeat (30) cycle(0, 1, 0, 16'h0);

        // Drop enable while dut_a sits in the gap after position 2.
        guard = 0;
        while (m_t[0] % 24 != 16 && guard < 100) begin
            cycle(0, 1, 0, 16'h0);
            guard++;
        end
        cycle(0, 0, 0, 16'h0);
        repeat (3) cycle(0, 0, 0, 16'h0);
        repeat (30) cycle(0, 1, 0, 16'h0);

        // Reset in the middle of a show phase.
        guard = 0;
        while (m_t[0] % 24 != 8 && guard < 100) begin
            cycle(0, 1, 0, 16'h0);
            guard++;
        end
        cycle(1, 1, 0, 16'h0);
        cycle(0, 1, 0, 16'h0);
        repeat (30) cycle(0, 1, 0, 16'h0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 49) != 0,
                  $urandom_range(0, 9) == 0, 16'($urandom));
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d unchecked entries, expected 0",
                     exp_a.size(), exp_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_sel_sequencer.md
# scan_sel_sequencer

Time-multiplexing sequencer that sits directly upstream of the 2-to-4 select decoder. It cycles a 2-bit `sel` through 0→1→2→3→0 at a programmable dwell rate. It inserts blanking gaps between positions to suppress ghosting and presents the 4-bit nibble belonging to the current position. The 16-bit payload is double-buffered, so new data takes effect only at a frame boundary and never tears a frame.

## Interface
Parameters:
- `DIV`, 50000, clock cycles each position is shown (≥1).
- `BLANK_CYC`, 4, blanking cycles between positions (0 = no gap).

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  scan enable; low forces IDLE.
- `load`  in  1  one-cycle strobe, capture `data`.
- `data`  in  16  payload; nibble k = `data[4k+3:4k]` belongs to position k.
- `sel`  out  2  current position, feeds decoder `sel`.
- `digit`  out  4  nibble of the active buffer at position `sel`.
- `blank`  out  1  1 = downstream must suppress output.
- `frame_done`  out  1  one-cycle pulse at each 3→0 wrap.

## Operation
- Registers:
  - `shadow[15:0]`, `active[15:0]`, `pending` flag.
  - Prescaler `cnt`, sized for max(DIV, BLANK_CYC).
  - State.
- Load handling:
  - `load`=1 in IDLE: `active` and `shadow` ← `data`; `pending` stays 0.
  - `load`=1 in SHOW or GAP: `shadow` ← `data`, `pending` ← 1.
  - Multiple loads within a frame: last one wins.
- States:
  - IDLE: `blank`=1, `sel`=0, `cnt`=0. Move to SHOW on the edge where `en`=1.
  - SHOW: `blank`=0. `cnt` counts 0..DIV-1. At `cnt`=DIV-1:
    - If BLANK_CYC>0, go to GAP with `cnt`←0.
    - Otherwise advance `sel` and stay in SHOW with `cnt`←0.
  - GAP: `blank`=1. `cnt` counts 0..BLANK_CYC-1. At the last count, advance `sel` and go to SHOW with `cnt`←0.
- Advance rule:
  - `sel` ← `sel`+1 mod 4.
  - When wrapping 3→0: `frame_done` pulses for exactly one cycle, registered with the `sel`=0 update.
  - On that same edge, `active` ← `data` if `load`=1; else `active` ← `shadow` if `pending`; else `active` is unchanged. `pending` ← 0 in every case.
- `digit` = `active[4*sel+3 : 4*sel]` in every state. It is combinational from registers, so it has no extra latency.
- `en` deasserted in any state: next edge enters IDLE with `sel`←0, `cnt`←0, `blank`←1, and `frame_done`←0. The pending load is kept and is promoted to `active` on entry to IDLE.
- Widths: `cnt` never exceeds its terminal value and never wraps past the terminal count. `sel` arithmetic is mod 4.

## Timing
- Reset values (asynchronous, immediate):
  - `sel`=0, `digit`=0, `blank`=1, `frame_done`=0.
  - `active`=0, `shadow`=0, `pending`=0, state IDLE.
- Reset released mid-frame restarts from IDLE. No partial state survives.
- From the first edge with `en`=1, the next cycle shows `sel`=0, `blank`=0.
- Each position shows for DIV cycles, then BLANK_CYC blank cycles.
- Frame period is 4·(DIV+BLANK_CYC) cycles.
- `sel` changes only while `blank`=1 (when BLANK_CYC>0). The first cycle with a new `sel` is a SHOW cycle.
- `frame_done` is high in the first cycle of position 0 of each frame after the first. It is not asserted on IDLE→SHOW entry.
- Load latency:
  - IDLE: `digit` reflects the new `data` on the next cycle.
  - Scanning: `digit` reflects the new `data` in the first cycle of the next frame.

## Test plan
(DIV=4, BLANK_CYC=2 unless stated.)
1. Reset then `en`=1, `data`=16'h4321 loaded in IDLE:
   - `sel` sequence 0,1,2,3 with `digit` 1,2,3,4.
   - Each position shows `blank`=0 for 4 cycles, then `blank`=1 for 2 cycles.
   - `frame_done` pulses once every 24 cycles.
2. Mid-frame `load` of 16'hDCBA while `sel`=1:
   - `digit` stays 2,3,4 for the rest of the frame.
   - The next frame shows A,B,C,D.
3. `load` of 16'h9999 on the exact wrap edge, with a pending 16'h5555:
   - The new frame shows 9 on all positions.
   - `pending`=0 afterwards.
4. `en` dropped while `sel`=2 in GAP:
   - Next cycle shows `sel`=0, `blank`=1, `frame_done`=0.
   - Re-enable restarts at `sel`=0 with no `frame_done` pulse.
5. BLANK_CYC=0, DIV=1:
   - `sel` advances every cycle 0,1,2,3,0.
   - `blank` stays 0 throughout.
   - `frame_done` is high every 4th cycle.
6. `rst` asserted mid-SHOW with non-zero `active`:
   - Outputs go immediately to `sel`=0, `digit`=0, `blank`=1.
   - After release with `en`=1, scanning restarts from position 0.
